// File: rtl/mixcol_iter.sv
// mixcol_iter: iterative AES MixColumns engine, COLS_PER_CYCLE columns transformed per clock.
// Latency: accept at edge N -> out_valid from edge N+4/COLS_PER_CYCLE; +1 idle cycle when starting from IDLE.
// Backpressure: result held stable in DONE until out_ready; in_ready=out_ready there for same-edge handoff.
// Optional feature macro MIXCOL_INV_EN: builds InvMixColumns and honours in_inv; otherwise forward only.
module mixcol_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mixcol_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // Counter step wraps to 0 for 4 columns/cycle; that group is always the last one anyway.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  state_t        state_q, state_d;
  logic [1:0]    col_q;
  logic [127:0]  src_q;
  logic          accept;
  logic          last_grp;
  logic [COLS_PER_CYCLE-1:0][31:0] grp_res;

  // Byte-wise xtime on a whole column: shift each byte, fold 0x1B where the top bit fell out.
  function automatic logic [31:0] xt4(input logic [31:0] w);
    logic [31:0] fold;
    fold = {{8{w[31]}}, {8{w[23]}}, {8{w[15]}}, {8{w[7]}}} & 32'h1b1b1b1b;
    return ((w & 32'h7f7f7f7f) << 1) ^ fold;
  endfunction

  // Column rotations: byte i of the result is byte i+k of the input (byte 0 = row 0 = MSB).
  function automatic logic [31:0] rot1(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [31:0] rot2(input logic [31:0] w);
    return {w[15:0], w[31:16]};
  endfunction
  function automatic logic [31:0] rot3(input logic [31:0] w);
    return {w[7:0], w[31:8]};
  endfunction

  // Forward: b_i = 2a_i ^ 3a_{i+1} ^ a_{i+2} ^ a_{i+3}, all four rows at once via rotations.
  function automatic logic [31:0] mix_fwd(input logic [31:0] a);
    logic [31:0] x2;
    x2 = xt4(a);
    return x2 ^ rot1(x2 ^ a) ^ rot2(a) ^ rot3(a);
  endfunction

`ifdef MIXCOL_INV_EN
  // Inverse: b_i = e a_i ^ b a_{i+1} ^ d a_{i+2} ^ 9 a_{i+3}, coefficients from an xtime chain.
  function automatic logic [31:0] mix_inv(input logic [31:0] a);
    logic [31:0] x2, x4, x8;
    x2 = xt4(a);
    x4 = xt4(x2);
    x8 = xt4(x4);
    return (x8 ^ x4 ^ x2) ^ rot1(x8 ^ x2 ^ a) ^ rot2(x8 ^ x4 ^ a) ^ rot3(x8 ^ a);
  endfunction

  logic inv_q;

  // Per-block direction register, captured only on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      inv_q <= 1'b0;
    end else if (accept) begin
      inv_q <= in_inv;
    end
  end

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    return inv_q ? mix_inv(a) : mix_fwd(a);
  endfunction
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    return mix_fwd(a);
  endfunction
`endif

  assign last_grp = (col_q == LAST_COL);
  assign accept   = in_valid & in_ready;

  // Transform the current column group from the captured source state.
  always_comb begin
    grp_res = '0;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      grp_res[k] = mix_col(src_q[127 - 32*(int'(col_q) + k) -: 32]);
    end
  end

  // Next-state and handshake outputs; in_ready never looks at in_valid.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = BUSY;
      end
      BUSY: begin
        if (last_grp) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (rst) in_ready = 1'b0;
  end

  // State register, column counter, source capture and column writes into the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      src_q     <= '0;
      out_state <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        src_q <= in_state;
        col_q <= '0;
      end else if (state_q == BUSY) begin
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
          out_state[127 - 32*(int'(col_q) + k) -: 32] <= grp_res[k];
        end
        col_q <= col_q + COL_STEP;
      end
    end
  end

endmodule

// File: tb/tb_mixcol_iter.sv
// tb_mixcol_iter: checks three instances (1, 2, 4 columns/cycle) against a GF(2^8) matrix model.
// Latency: measured per block from the accept edge.
// Backpressure: exercised with held-off out_ready and random out_ready on a 100-block stream.
module tb_mixcol_iter;

`ifdef MIXCOL_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6;
  localparam logic [127:0] R2 = 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iv   [3];
  logic         ir   [3];
  logic [127:0] ist  [3];
  logic         inv  [3];
  logic         ov   [3];
  logic         ordy [3];
  logic [127:0] ost  [3];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      mixcol_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv[g]),
        .in_ready  (ir[g]),
        .in_state  (ist[g]),
        .in_inv    (inv[g]),
        .out_valid (ov[g]),
        .out_ready (ordy[g]),
        .out_state (ost[g])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Generic GF(2^8) multiply, shift-and-add modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] aa;
    logic [7:0] p;
    aa = {1'b0, a};
    p  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa[7:0];
      aa = aa << 1;
      if (aa[8]) aa = aa ^ 9'h11b;
    end
    return p;
  endfunction

  // Circulant matrix times each column.
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input bit invd);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (invd) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else      base = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(base[(k - rr) & 3], s[127 - 32*c - 8*k -: 8]);
        end
        r[127 - 32*c - 8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block to instance d (entered at posedge+1), flip in_inv after accept,
  // and return latency in cycles and the held result without consuming it.
  task automatic run_block(input int d, input logic [127:0] s, input bit iinv,
                           output int lat, output logic [127:0] res);
    int w;
    iv[d] = 1'b1; ist[d] = s; inv[d] = iinv; ordy[d] = 1'b0;
    #1;
    w = 0;
    while (!ir[d] && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!ir[d]) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv[d] = 1'b0; inv[d] = ~iinv; ist[d] = rand128();
    lat = 0;
    while (!ov[d] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = ost[d];
  endtask

  task automatic consume(input int d);
    ordy[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0;
    chk("consumed_valid_low", ov[d], 0);
  endtask

  initial begin
    int           lat;
    logic [127:0] res, exp, cur, hold;
    bit           ri, fin, fout;
    logic [127:0] q[$];
    int           sent, got, cyc;

    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; ist[d] = '0; inv[d] = 1'b0; ordy[d] = 1'b0;
    end

    // Reset behaviour.
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk("ready_in_reset", ir[d], 0);
    rst = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ov[d], 0);
      chk("rst_out_state", ost[d], '0);
      chk("rst_in_ready", ir[d], 1);
    end
    @(posedge clk); #1;

    // Latency sweep with the known vectors.
    for (int d = 0; d < 3; d++) begin
      run_block(d, V1, 1'b0, lat, res);
      chk("fwd_v1", res, R1);
      chk("latency_v1", lat, 4 >> d);
      consume(d);
      run_block(d, V2, 1'b0, lat, res);
      chk("fwd_v2", res, R2);
      chk("latency_v2", lat, 4 >> d);
      consume(d);
    end

    // in_inv=1: inverse when built in, ignored otherwise.
    for (int d = 0; d < 3; d += 2) begin
      run_block(d, R1, 1'b1, lat, res);
      chk("inv_r1", res, INV_EN ? V1 : ref_mix(R1, 1'b0));
      consume(d);
      run_block(d, R2, 1'b1, lat, res);
      chk("inv_r2", res, INV_EN ? V2 : ref_mix(R2, 1'b0));
      consume(d);
      run_block(d, V1, 1'b1, lat, res);
      chk("inv_v1", res, INV_EN ? ref_mix(V1, 1'b1) : R1);
      consume(d);
    end

    // Random blocks on the multi-column instances.
    for (int d = 1; d < 3; d++) begin
      for (int i = 0; i < 6; i++) begin
        cur = rand128();
        ri  = 1'($urandom_range(0, 1));
        run_block(d, cur, ri, lat, res);
        chk("rand_multi", res, ref_mix(cur, INV_EN && ri));
        consume(d);
      end
    end

    // Backpressure: hold result for 10 cycles, then hand off on the same edge.
    run_block(0, V2, 1'b0, lat, res);
    hold = ost[0];
    chk("bp_first", hold, R2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", ov[0], 1);
      chk("bp_state", ost[0], R2);
      chk("bp_ready", ir[0], 0);
    end
    iv[0] = 1'b1; ist[0] = V1; inv[0] = 1'b0; ordy[0] = 1'b1;
    #1;
    chk("bp_ready_follows", ir[0], 1);
    @(posedge clk); #1;
    iv[0] = 1'b0; ordy[0] = 1'b0;
    chk("bp_handoff_busy", ov[0], 0);
    lat = 0;
    while (!ov[0] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("bp_next_latency", lat, 4);
    chk("bp_next_state", ost[0], R1);
    consume(0);

    // Reset two cycles into BUSY.
    iv[0] = 1'b1; ist[0] = V1; inv[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", ov[0], 0);
    chk("midrst_state", ost[0], '0);
    chk("midrst_ready", ir[0], 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_after", ir[0], 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("midrst_discard", ov[0], 0);
    end
    run_block(0, V2, 1'b0, lat, res);
    chk("midrst_next", res, R2);
    chk("midrst_next_lat", lat, 4);
    consume(0);

    // 100 back-to-back random blocks with random out_ready, scoreboarded.
    sent = 0; got = 0; cyc = 0;
    cur  = rand128();
    ri   = 1'($urandom_range(0, 1));
    while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
      ordy[0] = ($urandom_range(0, 3) != 0);
      iv[0]   = (sent < 100);
      ist[0]  = cur;
      inv[0]  = ri;
      #1;
      fin  = iv[0] && ir[0];
      fout = ov[0] && ordy[0];
      if (fout) begin
        chk("stream_has_expected", (q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("stream_data", ost[0], q.pop_front());
          got++;
        end
      end
      if (fin) begin
        q.push_back(ref_mix(cur, INV_EN && ri));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (fin) begin
        cur = rand128();
        ri  = 1'($urandom_range(0, 1));
      end
    end
    iv[0] = 1'b0; ordy[0] = 1'b0;
    chk("stream_sent", sent, 100);
    chk("stream_received", got, 100);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mixcol_iter.md
# mixcol_iter

Iterative, handshaked AES MixColumns engine that transforms a 128-bit state one or more columns per clock instead of all sixteen products in a single combinational cone. It sits between the ShiftRows and AddRoundKey stages of the round datapath. With the inverse option compiled in, it serves both the encrypt and decrypt paths. All GF(2^8) arithmetic uses the AES reduction polynomial 0x11B.

## Interface
- COLS_PER_CYCLE, 1, number of columns transformed per clock; legal values are 1, 2 and 4, any other value is an elaboration error.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  a state is offered on in_state.
- in_ready  output  1  the block can accept a state this cycle.
- in_state  input  128  input state, column-major: column c occupies [127-32c -: 32], row r byte of column c occupies [127-32c-8r -: 8].
- in_inv  input  1  1 selects InvMixColumns; sampled on accept.
- out_valid  output  1  out_state holds a finished result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_state  output  128  result, same byte order as in_state.

## Operation
- FSM states:
  - IDLE: waiting for input.
  - BUSY: column iteration in progress.
  - DONE: result held until consumed.
- IDLE: in_ready=1. On in_valid, register in_state and in_inv, clear the column counter and go to BUSY.
- BUSY: each cycle, columns col..col+COLS_PER_CYCLE-1 are transformed and written into the result register; col advances by COLS_PER_CYCLE.
  - When the last column group is written, go to DONE.
  - in_ready=0 throughout BUSY.
- Forward column transform, for bytes a0..a3:
  - b0=2a0^3a1^a2^a3
  - b1=a0^2a1^3a2^a3
  - b2=a0^a1^2a2^3a3
  - b3=3a0^a1^a2^2a3
- Inverse transform: same rotation pattern with coefficients 0e,0b,0d,09 in place of 02,03,01,01.
- Multiplication by 2 is xtime: shift left, then XOR 0x1B if the shifted-out bit was 1. Higher coefficients are built from xtime chains and XOR. Every intermediate value is 8 bits.
- DONE: out_valid=1 and out_state is stable.
  - out_ready=1: the result is consumed.
  - in_ready = out_ready in DONE, so a new state is accepted in the same cycle the old result leaves; DONE goes directly to BUSY.
  - If out_ready=1 and in_valid=0, go to IDLE.
- out_state is unchanged outside DONE except for column writes during BUSY; downstream qualifies it with out_valid only.
- Reset (any state, including mid-BUSY):
  - FSM goes to IDLE and the column counter clears.
  - out_valid=0 and out_state=0.
  - The in-flight block is discarded and never emitted.
  - in_ready is forced to 0 while rst=1.

## Timing
- Reset values: out_valid=0, out_state=128'h0, in_ready=1 on the first cycle after rst deasserts.
- Latency: a state accepted at edge N gives out_valid=1 from edge N+4/COLS_PER_CYCLE (4, 2 or 1 cycles).
- Throughput:
  - With out_ready held high: one state every 4/COLS_PER_CYCLE cycles.
  - From IDLE: one extra cycle.
- in_ready depends combinationally only on the FSM state, rst and out_ready. It has no path from in_valid.
- Stalls: out_valid stays high and out_state stays stable indefinitely while out_ready=0.
- in_inv is captured once per block; changing it mid-BUSY has no effect.

## Configuration
- MIXCOL_INV_EN
  - Defined: inverse coefficients and mux are present; in_inv selects the direction per block.
  - Undefined: only the forward transform is built, and in_inv is ignored (treated as 0). The port remains so the interface is fixed.

## Test plan
- Forward, COLS_PER_CYCLE=1: in_state=db135345_f20a225c_01010101_c6c6c6c6, in_inv=0 -> out_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid rises exactly 4 cycles after accept.
- Inverse (MIXCOL_INV_EN): in_state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, in_inv=1 -> db135345_f20a225c_01010101_c6c6c6c6. Repeat with d4d4d4d5_2d26314c_... vs. d5d5d7d6_4d7ebdf8_... in both directions.
- Latency sweep: COLS_PER_CYCLE=1, 2, 4 with the same vector -> identical out_state at latencies 4, 2 and 1.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable, in_ready=0. Raising out_ready with in_valid=1 -> next block accepted on the same edge, no lost or duplicated result over 100 random back-to-back blocks checked against a software model.
- Reset mid-BUSY: assert rst 2 cycles after accept (COLS_PER_CYCLE=1) -> out_valid=0 and out_state=0 next cycle, in_ready=1 after release, and the next block's result is correct.
- Without MIXCOL_INV_EN: in_inv=1 with in_state=db135345_... -> forward result 8e4da1bc_....
